// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 hex keypad scanner with debounce, key decode and press flag
// Optional history of the last four keys on oHistory when KEYPAD_HISTORY_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic        iClk,
  input  logic        iRst,
  output logic [3:0]  oCol,
  input  logic [3:0]  iRow,
  output logic [3:0]  oKey,
  output logic        oValid,
  output logic        oHeld,
  output logic [15:0] oHistory
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      row_m, row_s;
  logic [SW-1:0]   slot_cnt;
  logic            tick;
  logic [3:0]      cand, cand_nxt;
  logic [DW-1:0]   deb_cnt, deb_nxt;
  logic [DW-1:0]   rel_cnt, rel_nxt;
  logic [3:0]      col_nxt;
  logic [3:0]      col_rot;
  logic [3:0]      key_nxt;
  logic            held_nxt;
  logic            accept;
  logic            row_onehot;

  // Bit position of a one-hot nibble; zero for anything else.
  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] r;
    case (v)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  assign tick       = (slot_cnt == SW'(SCAN_DIV - 1));
  assign col_rot    = {oCol[2:0], oCol[3]};
  assign row_onehot = (row_s != 4'd0) && ((row_s & (row_s - 4'd1)) == 4'd0);

  // Two-flop synchronizer for the asynchronous row sense lines.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      row_m <= 4'd0;
      row_s <= 4'd0;
    end else begin
      row_m <= iRow;
      row_s <= row_m;
    end
  end

  // Column slot timer; the last clock of each slot is the sampling tick.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) slot_cnt <= '0;
    else if (tick) slot_cnt <= '0;
    else slot_cnt <= slot_cnt + SW'(1);
  end

  // Scanner state and output registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state   <= SCAN;
      oCol    <= 4'b0001;
      cand    <= 4'd0;
      deb_cnt <= '0;
      rel_cnt <= '0;
      oKey    <= 4'd0;
      oValid  <= 1'b0;
      oHeld   <= 1'b0;
    end else begin
      state   <= state_nxt;
      oCol    <= col_nxt;
      cand    <= cand_nxt;
      deb_cnt <= deb_nxt;
      rel_cnt <= rel_nxt;
      oKey    <= key_nxt;
      oValid  <= accept;
      oHeld   <= held_nxt;
    end
  end

  // Next-state logic: scan, debounce a single-row candidate, then wait for a debounced release.
  always_comb begin
    state_nxt = state;
    col_nxt   = oCol;
    cand_nxt  = cand;
    deb_nxt   = deb_cnt;
    rel_nxt   = rel_cnt;
    key_nxt   = oKey;
    held_nxt  = oHeld;
    accept    = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (row_onehot) begin
            cand_nxt = row_s;
            deb_nxt  = DW'(1);
            if (DEBOUNCE_TICKS == 1) accept = 1'b1;
            else state_nxt = DEBOUNCE;
          end else begin
            // Idle or ghosting multi-key pattern: keep scanning.
            col_nxt = col_rot;
          end
        end
        DEBOUNCE: begin
          if (row_s == cand) begin
            deb_nxt = deb_cnt + DW'(1);
            if (deb_nxt == DW'(DEBOUNCE_TICKS)) accept = 1'b1;
          end else begin
            // Bounce: retry from the same column before moving on.
            deb_nxt   = '0;
            state_nxt = SCAN;
          end
        end
        PRESSED: begin
          if (row_s == 4'd0) begin
            rel_nxt = rel_cnt + DW'(1);
            if (rel_nxt == DW'(DEBOUNCE_TICKS)) begin
              rel_nxt   = '0;
              held_nxt  = 1'b0;
              col_nxt   = col_rot;
              state_nxt = SCAN;
            end
          end else begin
            rel_nxt = '0;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
    if (accept) begin
      key_nxt   = {enc4(row_s), enc4(oCol)};
      held_nxt  = 1'b1;
      deb_nxt   = '0;
      rel_nxt   = '0;
      state_nxt = PRESSED;
    end
  end

`ifdef KEYPAD_HISTORY_EN
  logic [15:0] hist;

  // Shift each newly accepted key into the low digit.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) hist <= 16'h0000;
    else if (accept) hist <= {hist[11:0], key_nxt};
  end

  assign oHistory = hist;
`else
  assign oHistory = 16'h0000;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

  logic        iClk;
  logic        iRst;
  logic [3:0]  oCol;
  logic [3:0]  iRow;
  logic [3:0]  oKey;
  logic        oValid;
  logic        oHeld;
  logic [15:0] oHistory;

  int checks;
  int errors;
  int valid_cnt;

  logic       raw_mode;
  logic [3:0] raw_row;
  logic       key_down;
  logic [3:0] key_row;
  logic [3:0] key_col;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .iClk(iClk), .iRst(iRst), .oCol(oCol), .iRow(iRow),
    .oKey(oKey), .oValid(oValid), .oHeld(oHeld), .oHistory(oHistory)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Keypad matrix model: a pressed key connects its column to its row.
  always_comb begin
    if (raw_mode) iRow = raw_row;
    else if (key_down && (oCol == key_col)) iRow = key_row;
    else iRow = 4'b0000;
  end

  always @(negedge iClk) if (oValid === 1'b1) valid_cnt++;

  // Stimulus: press until accepted, then release until oHeld drops.
  task automatic press_key(input logic [3:0] r, input logic [3:0] c, output bit ok);
    int n;
    ok = 1'b1;
    key_row = r; key_col = c; key_down = 1'b1;
    n = 0;
    while (oValid !== 1'b1 && n < 200) begin @(negedge iClk); n++; end
    if (oValid !== 1'b1) ok = 1'b0;
    key_down = 1'b0;
    n = 0;
    while (oHeld !== 1'b0 && n < 200) begin @(negedge iClk); n++; end
    if (oHeld !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge iClk);
    checks++; if (oCol !== 4'b0001) begin errors++; $display("FAIL reset_col got %b exp 0001", oCol); end
    checks++; if (oKey !== 4'h0) begin errors++; $display("FAIL reset_key got %h exp 0", oKey); end
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", oValid); end
    checks++; if (oHeld !== 1'b0) begin errors++; $display("FAIL reset_held got %b exp 0", oHeld); end
    checks++; if (oHistory !== 16'h0) begin errors++; $display("FAIL reset_hist got %h exp 0", oHistory); end
    iRst = 1'b0;
  endtask

  task automatic test_idle_scan;
    logic [3:0] exp_col;
    logic [3:0] one;
    one = 4'b0001;
    for (int k = 1; k <= 32; k++) begin
      @(negedge iClk);
      exp_col = one << ((k / 4) % 4);
      checks++; if (oCol !== exp_col) begin errors++; $display("FAIL idle_col clk %0d got %b exp %b", k, oCol, exp_col); end
      checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL idle_valid clk %0d got %b exp 0", k, oValid); end
    end
  endtask

  task automatic test_single_press;
    int n;
    valid_cnt = 0;
    key_row = 4'b0100; key_col = 4'b0010; key_down = 1'b1;
    n = 0;
    while (oValid !== 1'b1 && n < 200) begin @(negedge iClk); n++; end
    checks++; if (n !== 16) begin errors++; $display("FAIL press_latency got %0d clk exp 16", n); end
    checks++; if (oKey !== 4'h9) begin errors++; $display("FAIL press_key got %h exp 9", oKey); end
    checks++; if (oHeld !== 1'b1) begin errors++; $display("FAIL press_held got %b exp 1", oHeld); end
    @(negedge iClk);
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL press_pulse_width got %b exp 0", oValid); end
    repeat (20) @(negedge iClk);
    key_down = 1'b0;
    repeat (6) @(negedge iClk);
    key_down = 1'b1;
    repeat (20) @(negedge iClk);
    checks++; if (oHeld !== 1'b1) begin errors++; $display("FAIL hold_bounce_held got %b exp 1", oHeld); end
    checks++; if (oCol !== 4'b0010) begin errors++; $display("FAIL hold_col got %b exp 0010", oCol); end
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL hold_valid_count got %0d exp 1", valid_cnt); end
    key_down = 1'b0;
    n = 0;
    while (oHeld !== 1'b0 && n < 100) begin @(negedge iClk); n++; end
    checks++; if (oHeld !== 1'b0) begin errors++; $display("FAIL release_held got %b exp 0", oHeld); end
    checks++; if (oCol !== 4'b0100) begin errors++; $display("FAIL release_col got %b exp 0100", oCol); end
    checks++; if (oKey !== 4'h9) begin errors++; $display("FAIL release_key got %h exp 9", oKey); end
  endtask

  task automatic test_bounce;
    int n;
    valid_cnt = 0;
    key_row = 4'b1000; key_col = 4'b0100; key_down = 1'b0;
    n = 0;
    while (oCol !== key_col && n < 64) begin @(negedge iClk); n++; end
    checks++; if (oCol !== key_col) begin errors++; $display("FAIL bounce_align got %b exp %b", oCol, key_col); end
    key_down = 1'b1;
    repeat (5) @(negedge iClk);
    key_down = 1'b0;
    repeat (4) @(negedge iClk);
    key_down = 1'b1;
    repeat (8) @(negedge iClk);
    key_down = 1'b0;
    repeat (4) @(negedge iClk);
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL bounce_no_valid got %0d exp 0", valid_cnt); end
    checks++; if (oCol !== 4'b0100) begin errors++; $display("FAIL bounce_col_frozen got %b exp 0100", oCol); end
    key_down = 1'b1;
    repeat (30) @(negedge iClk);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL bounce_stable_valid got %0d exp 1", valid_cnt); end
    checks++; if (oKey !== 4'hE) begin errors++; $display("FAIL bounce_key got %h exp e", oKey); end
    key_down = 1'b0;
    n = 0;
    while (oHeld !== 1'b0 && n < 100) begin @(negedge iClk); n++; end
    checks++; if (oHeld !== 1'b0) begin errors++; $display("FAIL bounce_release got %b exp 0", oHeld); end
  endtask

  task automatic test_multi_key;
    logic [3:0] seen;
    seen = 4'b0000;
    valid_cnt = 0;
    raw_mode = 1'b1; raw_row = 4'b0011;
    for (int k = 0; k < 64; k++) begin
      @(negedge iClk);
      seen = seen | oCol;
    end
    checks++; if (seen !== 4'hF) begin errors++; $display("FAIL multi_rotate got %b exp 1111", seen); end
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL multi_valid got %0d exp 0", valid_cnt); end
    checks++; if (oHeld !== 1'b0) begin errors++; $display("FAIL multi_held got %b exp 0", oHeld); end
    raw_mode = 1'b0; raw_row = 4'b0000;
    repeat (4) @(negedge iClk);
  endtask

  task automatic test_reset_mid;
    int n;
    valid_cnt = 0;
    key_row = 4'b0010; key_col = 4'b1000; key_down = 1'b0;
    n = 0;
    while (oCol !== key_col && n < 64) begin @(negedge iClk); n++; end
    key_down = 1'b1;
    repeat (6) @(negedge iClk);
    checks++; if (oKey !== 4'hE) begin errors++; $display("FAIL rstdeb_prekey got %h exp e", oKey); end
    #2 iRst = 1'b1;
    #1;
    checks++; if (oCol !== 4'b0001) begin errors++; $display("FAIL rstdeb_col got %b exp 0001", oCol); end
    checks++; if (oKey !== 4'h0) begin errors++; $display("FAIL rstdeb_key got %h exp 0", oKey); end
    checks++; if (oHeld !== 1'b0) begin errors++; $display("FAIL rstdeb_held got %b exp 0", oHeld); end
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL rstdeb_valid got %0d exp 0", valid_cnt); end
    key_down = 1'b0;
    @(negedge iClk);
    iRst = 1'b0;
    key_down = 1'b1;
    n = 0;
    while (oValid !== 1'b1 && n < 200) begin @(negedge iClk); n++; end
    checks++; if (oKey !== 4'h7) begin errors++; $display("FAIL rstprs_prekey got %h exp 7", oKey); end
    repeat (5) @(negedge iClk);
    checks++; if (oHeld !== 1'b1) begin errors++; $display("FAIL rstprs_preheld got %b exp 1", oHeld); end
    #2 iRst = 1'b1;
    #1;
    checks++; if (oCol !== 4'b0001) begin errors++; $display("FAIL rstprs_col got %b exp 0001", oCol); end
    checks++; if (oKey !== 4'h0) begin errors++; $display("FAIL rstprs_key got %h exp 0", oKey); end
    checks++; if (oHeld !== 1'b0) begin errors++; $display("FAIL rstprs_held got %b exp 0", oHeld); end
    key_down = 1'b0;
    @(negedge iClk);
    iRst = 1'b0;
    repeat (4) @(negedge iClk);
  endtask

  task automatic test_history;
    logic [3:0] rows [4];
    logic [3:0] cols [4];
    logic [3:0] exp_key;
    logic [15:0] exp_hist;
    bit ok;
    rows[0] = 4'b0001; cols[0] = 4'b0010;
    rows[1] = 4'b0001; cols[1] = 4'b0100;
    rows[2] = 4'b0001; cols[2] = 4'b1000;
    rows[3] = 4'b0010; cols[3] = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      exp_key = 4'(i + 1);
      press_key(rows[i], cols[i], ok);
      checks++; if (!ok) begin errors++; $display("FAIL hist_press%0d timeout got 0 exp 1", i + 1); end
      checks++; if (oKey !== exp_key) begin errors++; $display("FAIL hist_key%0d got %h exp %h", i + 1, oKey, exp_key); end
    end
`ifdef KEYPAD_HISTORY_EN
    exp_hist = 16'h1234;
`else
    exp_hist = 16'h0000;
`endif
    checks++; if (oHistory !== exp_hist) begin errors++; $display("FAIL hist_value got %h exp %h", oHistory, exp_hist); end
  endtask

  initial begin
    checks = 0; errors = 0; valid_cnt = 0;
    iRst = 1'b1;
    raw_mode = 1'b0; raw_row = 4'b0000;
    key_down = 1'b0; key_row = 4'b0000; key_col = 4'b0001;
    test_reset;
    test_idle_scan;
    test_single_press;
    test_bounce;
    test_multi_key;
    test_reset_mid;
    test_history;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
